target_editor: RTL and testbench

TARGET_EDITOR -- requirements
Module: target_editor

---
 rtl/target_editor.sv | 143 ++++++++++++++
 tb/tb_target_editor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/target_editor.sv
// Field-editable target register: switches and keys are synchronised and debounced,
// and a small FSM applies commit/restore edits with a registered strobe.
module target_editor #(
  parameter int TARGET_W = 32,
  parameter int FIELD_W = 8,
  parameter logic [TARGET_W-1:0] DEFAULT_TARGET = TARGET_W'(32'h4995CDD1),
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          sw,
  input  logic                key_commit_n,
  input  logic                key_restore_n,
  output logic                disp_sel,
  output logic                clk_sel,
  output logic [TARGET_W-1:0] target,
  output logic                target_stb,
  output logic                pos_err,
  output logic                busy
);

  // state | meaning
  // IDLE  | waiting for a commit or restore press
  // WRITE | applying the latched operation for one cycle
  // HOLD  | waiting for both keys to be released
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam int N_FIELDS = TARGET_W / FIELD_W;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Keys idle high, switches idle low.
  localparam logic [11:0] IN_RST = 12'hC00;

  logic [11:0]      raw, sync1, sync2, deb;
  logic [CNT_W-1:0] cnt [12];

  assign raw = {key_restore_n, key_commit_n, sw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IN_RST;
      sync2 <= IN_RST;
      deb   <= IN_RST;
      for (int i = 0; i < 12; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 12; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign disp_sel = deb[9];
  assign clk_sel  = deb[8];

  logic commit_q, restore_q;
  logic press_commit, press_restore;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q  <= 1'b1;
      restore_q <= 1'b1;
    end else begin
      commit_q  <= deb[10];
      restore_q <= deb[11];
    end
  end

  assign press_commit  = commit_q & ~deb[10];
  assign press_restore = restore_q & ~deb[11];

  logic [1:0]          pos;
  logic [FIELD_W-1:0]  user_val;
  logic                pos_ok;
  logic [TARGET_W-1:0] field_target;

  assign pos      = deb[7:6];
  assign user_val = FIELD_W'(deb[5:0]) << (FIELD_W - 6);
  assign pos_ok   = int'(pos) < N_FIELDS;

  always_comb begin
    field_target = target;
    for (int i = 0; i < N_FIELDS; i++) begin
      if (int'(pos) == i) field_target[i*FIELD_W +: FIELD_W] = user_val;
    end
  end

  logic [1:0] state;
  logic       op_restore;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_restore <= 1'b0;
      target     <= DEFAULT_TARGET;
      target_stb <= 1'b0;
      pos_err    <= 1'b0;
    end else begin
      target_stb <= 1'b0;
      pos_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press_restore) begin
            op_restore <= 1'b1;
            state      <= S_WRITE;
          end else if (press_commit) begin
            op_restore <= 1'b0;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (op_restore) begin
            target     <= DEFAULT_TARGET;
            target_stb <= 1'b1;
          end else if (pos_ok) begin
            target     <= field_target;
            target_stb <= 1'b1;
          end else begin
            pos_err <= 1'b1;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (deb[10] && deb[11]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_target_editor.sv
// Bench for target_editor: 32-bit and 16-bit instances share stimulus and are
// checked every cycle against an event-level model, plus literal spot checks.
module tb_target_editor;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic       kc, kr;

  logic        a_disp, a_clk, a_stb, a_perr, a_busy;
  logic [31:0] a_target;
  logic        b_disp, b_clk, b_stb, b_perr, b_busy;
  logic [15:0] b_target;

  always #5 clk = ~clk;

  target_editor #(.DEBOUNCE_CYCLES(DB)) u32 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key_commit_n(kc), .key_restore_n(kr),
    .disp_sel(a_disp), .clk_sel(a_clk), .target(a_target), .target_stb(a_stb),
    .pos_err(a_perr), .busy(a_busy));

  target_editor #(.TARGET_W(16), .DEFAULT_TARGET(16'hCDD1), .DEBOUNCE_CYCLES(DB)) u16 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key_commit_n(kc), .key_restore_n(kr),
    .disp_sel(b_disp), .clk_sel(b_clk), .target(b_target), .target_stb(b_stb),
    .pos_err(b_perr), .busy(b_busy));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: raw inputs pass a 2-cycle delay line; a debounced bit flips once the
  // delayed input has disagreed with it for DB straight cycles. Press events
  // open an edit whose result lands two cycles after detection; the edit stays
  // busy until both debounced keys read high again.
  logic [11:0] m_s1, m_s2, m_deb;
  int          m_run [12];
  logic        m_kc_prev, m_kr_prev;
  int          m_phase;      // 0 free, 1 edit pending, 2 waiting for release
  logic        m_restore;
  logic [31:0] m_t32;
  logic [15:0] m_t16;
  logic        m_stb32, m_stb16, m_pe32, m_pe16;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 12'hC00; m_s2 = 12'hC00; m_deb = 12'hC00;
      for (int i = 0; i < 12; i++) m_run[i] = 0;
      m_kc_prev = 1; m_kr_prev = 1; m_phase = 0; m_restore = 0;
      m_t32 = 32'h4995CDD1; m_t16 = 16'hCDD1;
      m_stb32 = 0; m_stb16 = 0; m_pe32 = 0; m_pe16 = 0;
    end else begin
      logic pc, pr;
      int p;
      logic [31:0] v;
      pc = m_kc_prev && !m_deb[10];
      pr = m_kr_prev && !m_deb[11];
      p = int'(m_deb[7:6]);
      v = {24'd0, m_deb[5:0], 2'b00};
      m_stb32 = 0; m_stb16 = 0; m_pe32 = 0; m_pe16 = 0;
      if (m_phase == 0) begin
        if (pr || pc) begin m_phase = 1; m_restore = pr; end
      end else if (m_phase == 1) begin
        if (m_restore) begin
          m_t32 = 32'h4995CDD1; m_t16 = 16'hCDD1; m_stb32 = 1; m_stb16 = 1;
        end else begin
          m_t32 = (m_t32 & ~(32'hFF << (8*p))) | (v << (8*p));
          m_stb32 = 1;
          if (p < 2) begin
            m_t16 = 16'((32'(m_t16) & ~(32'hFF << (8*p))) | (v << (8*p)));
            m_stb16 = 1;
          end else m_pe16 = 1;
        end
        m_phase = 2;
      end else if (m_deb[10] && m_deb[11]) m_phase = 0;
      m_kc_prev = m_deb[10];
      m_kr_prev = m_deb[11];
      for (int i = 0; i < 12; i++) begin
        if (m_s2[i] == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
        end
      end
      m_s2 = m_s1;
      m_s1 = {kr, kc, sw};
    end
  end

  logic run_cmp = 0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("target32", a_target, m_t32);
      chk("stb32", 32'(a_stb), 32'(m_stb32));
      chk("perr32", 32'(a_perr), 32'(m_pe32));
      chk("busy32", 32'(a_busy), 32'(m_phase != 0));
      chk("disp32", 32'(a_disp), 32'(m_deb[9]));
      chk("clksel32", 32'(a_clk), 32'(m_deb[8]));
      chk("target16", 32'(b_target), 32'(m_t16));
      chk("stb16", 32'(b_stb), 32'(m_stb16));
      chk("perr16", 32'(b_perr), 32'(m_pe16));
      chk("busy16", 32'(b_busy), 32'(m_phase != 0));
    end
  end

  int c_stb32 = 0, c_stb16 = 0, c_pe16 = 0;
  always @(negedge clk) begin
    if (a_stb) c_stb32++;
    if (b_stb) c_stb16++;
    if (b_perr) c_pe16++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic zero_counts();
    c_stb32 = 0; c_stb16 = 0; c_pe16 = 0;
  endtask

  task automatic commit_press(input int low, input int high);
    kc = 1'b0; cyc(low);
    kc = 1'b1; cyc(high);
  endtask

  initial begin
    sw = '0; kc = 1'b1; kr = 1'b1; rst_n = 1'b0;
    cyc(3);
    run_cmp = 1;
    cyc(2);
    rst_n = 1'b1;
    zero_counts();
    cyc(100);
    chk("reset_target", a_target, 32'h4995CDD1);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_no_stb", 32'(c_stb32), 32'd0);

    // Commit 0x3F into field 2.
    sw = {2'b00, 2'd2, 6'h3F}; cyc(10);
    zero_counts();
    kc = 1'b0; cyc(20);
    chk("busy_while_held", 32'(a_busy), 32'd1);
    kc = 1'b1; cyc(3);
    chk("busy_until_release", 32'(a_busy), 32'd1);
    cyc(12);
    chk("commit_target", a_target, 32'h49FCCDD1);
    chk("commit_one_stb", 32'(c_stb32), 32'd1);
    chk("commit_idle", 32'(a_busy), 32'd0);
    chk("w16_p2_perr", 32'(c_pe16), 32'd1);
    chk("w16_p2_no_stb", 32'(c_stb16), 32'd0);

    // Three-cycle glitch must not register.
    zero_counts();
    commit_press(3, 15);
    chk("glitch_no_stb", 32'(c_stb32), 32'd0);
    chk("glitch_target", a_target, 32'h49FCCDD1);

    // Field 3 is out of range for the 16-bit instance.
    sw = {2'b00, 2'd3, 6'h15}; cyc(10);
    zero_counts();
    commit_press(15, 15);
    chk("w16_p3_perr", 32'(c_pe16), 32'd1);
    chk("w16_p3_no_stb", 32'(c_stb16), 32'd0);
    chk("w16_p3_target", 32'(b_target), 32'h0000CDD1);
    chk("w32_p3_target", a_target, 32'h54FCCDD1);

    // Simultaneous commit and restore: restore wins.
    zero_counts();
    kc = 1'b0; kr = 1'b0; cyc(15);
    kc = 1'b1; kr = 1'b1; cyc(15);
    chk("both_target", a_target, 32'h4995CDD1);
    chk("both_one_stb", 32'(c_stb32), 32'd1);
    chk("both_w16_target", 32'(b_target), 32'h0000CDD1);

    // Reset during HOLD, then a fresh commit.
    sw = {2'b00, 2'd2, 6'h3F}; cyc(10);
    kc = 1'b0;
    begin
      int k;
      k = 0;
      while (!a_busy && k < 40) begin cyc(1); k++; end
      chk("reach_busy", 32'(k < 40), 32'd1);
    end
    cyc(4);
    rst_n = 1'b0; cyc(2);
    chk("mid_reset_target", a_target, 32'h4995CDD1);
    chk("mid_reset_busy", 32'(a_busy), 32'd0);
    kc = 1'b1; cyc(3);
    rst_n = 1'b1; cyc(10);
    chk("post_reset_idle", 32'(a_busy), 32'd0);
    zero_counts();
    commit_press(20, 15);
    chk("recommit_target", a_target, 32'h49FCCDD1);
    chk("recommit_one_stb", 32'(c_stb32), 32'd1);

    // Random traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int mode;
      sw = 10'($urandom);
      mode = int'($urandom_range(0, 3));
      kc = !(mode == 1 || mode == 3);
      kr = !(mode == 2 || mode == 3);
      cyc(int'($urandom_range(1, 10)));
      kc = 1'b1; kr = 1'b1;
      cyc(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0; cyc(int'($urandom_range(1, 3)));
        rst_n = 1'b1; cyc(2);
      end
    end
    cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
